// File: rtl/spi_adc_scan_reader_if.sv
// Sample capture stream from the SPI ADC scan reader towards the logger.
// The master side drives each completed sample and its channel tag.
interface spi_adc_scan_reader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH_W   = 4
);
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   data_ch;
    logic              data_valid;

    modport master (output data_out, data_ch, data_valid);
    modport slave  (input  data_out, data_ch, data_valid);
endinterface

// File: rtl/spi_adc_scan_reader.sv
// SPI master for serial ADCs: scans NUM_CH channels per trigger, reading DATA_W-bit samples
// MSB-first, with nCS released for CLK_DIV cycles between channels.
module spi_adc_scan_reader #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned CLK_DIV = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  trig_mode,
    input  logic                  start,
    input  logic                  nDRDY,
    input  logic                  SDIN,
    output logic                  SCLK,
    output logic                  nCS,
    output logic [CH_W-1:0]       adc_ch,
    spi_adc_scan_reader_if.master cap,
    output logic                  busy,
    output logic                  overrun
);
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned      BIT_W    = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [DATA_W-1:0] shift_q, shift_n, dout_q, dout_n;
    logic [CH_W-1:0]   dch_q, dch_n;
    logic              sclk_q, sclk_n, ncs_q, ncs_n, busy_q, busy_n;
    logic              dvalid_q, dvalid_n, ovr_q, ovr_n;
    logic [2:0]        drdy_sync;
    logic              drdy_fall, trig, div_end;

    // Two synchroniser flops plus one history flop for the falling-edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drdy_sync <= '1;
        else       drdy_sync <= {drdy_sync[1:0], nDRDY};
    end

    assign drdy_fall = drdy_sync[2] & ~drdy_sync[1];
    assign trig      = enable & (trig_mode ? start : drdy_fall);
    assign div_end   = (div_cnt == DIV_LAST);

    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        ch_n     = ch;
        sclk_n   = sclk_q;
        shift_n  = shift_q;
        dout_n   = dout_q;
        dch_n    = dch_q;
        dvalid_n = 1'b0;
        ovr_n    = ovr_q;
        if (trig) ovr_n = (state != IDLE);
        unique case (state)
            IDLE: if (trig) begin
                state_n = SETUP;
                ch_n    = '0;
                div_n   = '0;
            end
            SETUP: if (div_end) begin
                state_n = SHIFT;
                div_n   = '0;
                bit_n   = '0;
            end else begin
                div_n = div_cnt + DIV_W'(1);
            end
            SHIFT: if (!div_end) begin
                div_n = div_cnt + DIV_W'(1);
            end else begin
                div_n = '0;
                if (!sclk_q) begin
                    sclk_n  = 1'b1;
                    shift_n = {shift_q[DATA_W-2:0], SDIN};
                end else begin
                    sclk_n = 1'b0;
                    if (bit_cnt == BIT_LAST) state_n = HOLD;
                    else                     bit_n   = bit_cnt + BIT_W'(1);
                end
            end
            HOLD: if (div_end) begin
                state_n  = GAP;
                div_n    = '0;
                dout_n   = shift_q;
                dch_n    = ch;
                dvalid_n = 1'b1;
            end else begin
                div_n = div_cnt + DIV_W'(1);
            end
            GAP: if (div_end) begin
                div_n = '0;
                if (ch == CH_LAST) begin
                    state_n = IDLE;
                end else begin
                    state_n = SETUP;
                    ch_n    = ch + CH_W'(1);
                end
            end else begin
                div_n = div_cnt + DIV_W'(1);
            end
            default: state_n = IDLE;
        endcase
        // Pin-level outputs are registered from the next state so they change glitch-free.
        ncs_n  = !((state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD));
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            ch       <= '0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            busy_q   <= 1'b0;
            shift_q  <= '0;
            dout_q   <= '0;
            dch_q    <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            ch       <= ch_n;
            sclk_q   <= sclk_n;
            ncs_q    <= ncs_n;
            busy_q   <= busy_n;
            shift_q  <= shift_n;
            dout_q   <= dout_n;
            dch_q    <= dch_n;
            dvalid_q <= dvalid_n;
            ovr_q    <= ovr_n;
        end
    end

    assign SCLK           = sclk_q;
    assign nCS            = ncs_q;
    assign adc_ch         = ch;
    assign busy           = busy_q;
    assign overrun        = ovr_q;
    assign cap.data_out   = dout_q;
    assign cap.data_ch    = dch_q;
    assign cap.data_valid = dvalid_q;
endmodule

// File: tb/tb_spi_adc_scan_reader.sv
// Bench for spi_adc_scan_reader: three configurations driven by behavioural ADC models,
// with sample streams checked against words chosen by the bench.
module tb_spi_adc_scan_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, trig_mode;
    logic start1, start4, start2, ndrdy1, ndrdy4, ndrdy2;
    logic sclk1, sclk4, sclk2, ncs1, ncs4, ncs2, sdin1, sdin4, sdin2;
    logic busy1, busy4, busy2, ovr1, ovr4, ovr2;
    logic [3:0] ach1, ach4, ach2;

    spi_adc_scan_reader_if #(.DATA_W(16), .CH_W(4)) cap1 ();
    spi_adc_scan_reader_if #(.DATA_W(16), .CH_W(4)) cap4 ();
    spi_adc_scan_reader_if #(.DATA_W(2),  .CH_W(4)) cap2 ();

    spi_adc_scan_reader #(.DATA_W(16), .NUM_CH(1), .CH_W(4), .CLK_DIV(4)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .trig_mode(trig_mode), .start(start1),
        .nDRDY(ndrdy1), .SDIN(sdin1), .SCLK(sclk1), .nCS(ncs1), .adc_ch(ach1), .cap(cap1),
        .busy(busy1), .overrun(ovr1));
    spi_adc_scan_reader #(.DATA_W(16), .NUM_CH(4), .CH_W(4), .CLK_DIV(4)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .trig_mode(trig_mode), .start(start4),
        .nDRDY(ndrdy4), .SDIN(sdin4), .SCLK(sclk4), .nCS(ncs4), .adc_ch(ach4), .cap(cap4),
        .busy(busy4), .overrun(ovr4));
    spi_adc_scan_reader #(.DATA_W(2), .NUM_CH(1), .CH_W(4), .CLK_DIV(1)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .trig_mode(trig_mode), .start(start2),
        .nDRDY(ndrdy2), .SDIN(sdin2), .SCLK(sclk2), .nCS(ncs2), .adc_ch(ach2), .cap(cap2),
        .busy(busy2), .overrun(ovr2));

    // ADC models: the k-th bit of a frame (MSB first) is presented until the k-th SCLK rise.
    logic [15:0] word1, word4 [4];
    logic [1:0]  word2;
    int unsigned rc1, rc4, rc2;
    always @(negedge ncs1) rc1 = 0;
    always @(negedge ncs4) rc4 = 0;
    always @(negedge ncs2) rc2 = 0;
    always @(posedge sclk1) rc1 = rc1 + 1;
    always @(posedge sclk4) rc4 = rc4 + 1;
    always @(posedge sclk2) rc2 = rc2 + 1;
    assign sdin1 = (rc1 < 16) ? word1[15 - rc1] : 1'b0;
    assign sdin4 = (rc4 < 16) ? word4[ach4[1:0]][15 - rc4] : 1'b0;
    assign sdin2 = (rc2 < 2)  ? word2[1 - rc2] : 1'b0;

    logic sclk_a [3], ncs_a [3], busy_a [3], dv_a [3];
    logic sclk_p [3], ncs_p [3], dv_p [3];
    assign sclk_a[0] = sclk1; assign sclk_a[1] = sclk4; assign sclk_a[2] = sclk2;
    assign ncs_a[0]  = ncs1;  assign ncs_a[1]  = ncs4;  assign ncs_a[2]  = ncs2;
    assign busy_a[0] = busy1; assign busy_a[1] = busy4; assign busy_a[2] = busy2;
    assign dv_a[0] = cap1.data_valid; assign dv_a[1] = cap4.data_valid; assign dv_a[2] = cap2.data_valid;

    int unsigned cyc = 0;
    int unsigned nfall [3], rises [3], shi [3], dvhi [3], dvrise [3], gapc [3], ncs_cyc [3], dv_cyc [3];
    int unsigned obs_d [$], obs_c [$], dvq [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ncs_p[d] && !ncs_a[d]) begin nfall[d]++; ncs_cyc[d] = cyc; end
            if (sclk_a[d] && !sclk_p[d]) rises[d]++;
            if (sclk_a[d]) shi[d]++;
            if (dv_a[d]) begin
                dvhi[d]++;
                dv_cyc[d] = cyc;
                if (!dv_p[d]) dvrise[d]++;
            end
            if (busy_a[d] && ncs_a[d]) gapc[d]++;
            sclk_p[d] = sclk_a[d];
            ncs_p[d]  = ncs_a[d];
            dv_p[d]   = dv_a[d];
        end
        if (cap4.data_valid) begin
            obs_d.push_back(int'(cap4.data_out));
            obs_c.push_back(int'(cap4.data_ch));
            dvq.push_back(cyc);
        end
    end

    int unsigned n_pass = 0, n_total = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++) begin
            nfall[d] = 0; rises[d] = 0; shi[d] = 0; dvhi[d] = 0; dvrise[d] = 0; gapc[d] = 0;
        end
        obs_d.delete(); obs_c.delete(); dvq.delete();
    endtask

    task automatic wait_busy(input int d, input logic lvl, input int budget, input string tag);
        int n = 0;
        while (busy_a[d] !== lvl && n < budget) begin tick(1); n++; end
        chk(tag, 32'(busy_a[d]), 32'(lvl));
    endtask

    task automatic pulse(input int d);
        case (d)
            0: start1 = 1'b1;
            1: start4 = 1'b1;
            default: start2 = 1'b1;
        endcase
        tick(1);
        start1 = 1'b0; start4 = 1'b0; start2 = 1'b0;
    endtask

    // Expected stream for one u4 scan: channels 0..3 in order, each carrying its model word.
    task automatic check_scan4(input string tag);
        chk({tag, "_count"}, obs_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_ch"},   (i < obs_c.size()) ? obs_c[i] : 32'hFFFF_FFFF, i);
            chk({tag, "_data"}, (i < obs_d.size()) ? obs_d[i] : 32'hFFFF_FFFF, 32'(word4[i]));
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; trig_mode = 1'b0;
        start1 = 1'b0; start4 = 1'b0; start2 = 1'b0;
        ndrdy1 = 1'b1; ndrdy4 = 1'b1; ndrdy2 = 1'b1;
        word1 = '0; word2 = '0;
        for (int i = 0; i < 4; i++) word4[i] = '0;
        tick(3);
        chk("rst_sclk", 32'(sclk1), 0);
        chk("rst_ncs", 32'(ncs1), 1);
        chk("rst_adc_ch", 32'(ach4), 0);
        chk("rst_data_out", 32'(cap4.data_out), 0);
        chk("rst_data_ch", 32'(cap4.data_ch), 0);
        chk("rst_valid", 32'(cap1.data_valid), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_overrun", 32'(ovr4), 0);
        reset = 1'b0;
        tick(3);

        // Single channel, nDRDY trigger.
        clr(); word1 = 16'hA5C3; trig_mode = 1'b0; ndrdy1 = 1'b0;
        wait_busy(0, 1'b1, 10, "t1_busy_rise");
        wait_busy(0, 1'b0, 300, "t1_busy_fall");
        ndrdy1 = 1'b1;
        chk("t1_ncs_windows", nfall[0], 1);
        chk("t1_sclk_rises", rises[0], 16);
        chk("t1_data", 32'(cap1.data_out), 32'hA5C3);
        chk("t1_ch", 32'(cap1.data_ch), 0);
        chk("t1_valid_cycles", dvhi[0], 1);
        chk("t1_valid_pulses", dvrise[0], 1);
        chk("t1_latency", dv_cyc[0] - ncs_cyc[0], 136);
        chk("t1_overrun", 32'(ovr1), 0);

        // Four-channel scan, start trigger.
        clr(); trig_mode = 1'b1;
        for (int i = 0; i < 4; i++) word4[i] = 16'h1110 + 16'(i);
        pulse(1);
        wait_busy(1, 1'b1, 10, "t2_busy_rise");
        wait_busy(1, 1'b0, 1000, "t2_busy_fall");
        check_scan4("t2");
        chk("t2_ncs_windows", nfall[1], 4);
        chk("t2_gap_cycles", gapc[1], 16);
        chk("t2_ch_period", (dvq.size() == 4) ? dvq[3] - dvq[0] : 0, 3 * 140);
        chk("t2_overrun", 32'(ovr4), 0);

        // Start mid-scan is an overrun and changes nothing else.
        clr(); pulse(1); tick(50); pulse(1);
        wait_busy(1, 1'b0, 1000, "t3_busy_fall");
        chk("t3_overrun_set", 32'(ovr4), 1);
        chk("t3_ncs_windows", nfall[1], 4);
        check_scan4("t3");

        // Accepted start clears overrun; a start on the cycle busy drops is still an overrun.
        clr(); pulse(1); tick(2);
        chk("t3_overrun_clr", 32'(ovr4), 0);
        for (int n = 0; n < 1000 && obs_d.size() < 4; n++) tick(1);
        chk("t3_last_sample", obs_d.size(), 4);
        tick(3);
        start4 = 1'b1; tick(1); start4 = 1'b0;
        chk("t3_edge_busy", 32'(busy4), 0);
        chk("t3_edge_overrun", 32'(ovr4), 1);
        tick(5);
        chk("t3_edge_no_scan", nfall[1], 4);
        clr(); pulse(1); tick(2);
        chk("t3_overrun_clr2", 32'(ovr4), 0);
        wait_busy(1, 1'b0, 1000, "t3_busy_fall2");

        // Reset in the middle of the shift phase.
        clr(); word1 = 16'h3C5A; pulse(0);
        for (int n = 0; n < 300 && rises[0] < 7; n++) tick(1);
        chk("t4_reached_bit7", rises[0], 7);
        reset = 1'b1; #1;
        chk("t4_sclk", 32'(sclk1), 0);
        chk("t4_ncs", 32'(ncs1), 1);
        chk("t4_busy", 32'(busy1), 0);
        tick(2); reset = 1'b0; tick(2);
        chk("t4_no_valid", dvrise[0], 0);
        chk("t4_data_cleared", 32'(cap1.data_out), 0);
        word1 = 16'($urandom); pulse(0);
        wait_busy(0, 1'b1, 10, "t4_busy_rise");
        wait_busy(0, 1'b0, 300, "t4_busy_fall");
        chk("t4_clean_data", 32'(cap1.data_out), 32'(word1));
        chk("t4_clean_valid", dvrise[0], 1);

        // Minimum divider and width.
        clr(); word2 = 2'b10; pulse(2);
        wait_busy(2, 1'b1, 10, "t5_busy_rise");
        wait_busy(2, 1'b0, 50, "t5_busy_fall");
        chk("t5_data", 32'(cap2.data_out), 2);
        chk("t5_rises", rises[2], 2);
        chk("t5_sclk_high", shi[2], 2);
        chk("t5_latency", dv_cyc[2] - ncs_cyc[2], 6);
        chk("t5_valid", dvhi[2], 1);

        // Disabled triggers, then the unselected source in each mode.
        clr(); enable = 1'b0;
        for (int m = 0; m < 2; m++) begin
            trig_mode = m[0];
            start1 = 1'b1; start4 = 1'b1; start2 = 1'b1; tick(1);
            start1 = 1'b0; start4 = 1'b0; start2 = 1'b0;
            ndrdy1 = 1'b0; ndrdy4 = 1'b0; ndrdy2 = 1'b0; tick(6);
            ndrdy1 = 1'b1; ndrdy4 = 1'b1; ndrdy2 = 1'b1; tick(6);
        end
        chk("t6_dis_u1", nfall[0], 0);
        chk("t6_dis_u4", nfall[1], 0);
        chk("t6_dis_u2", nfall[2], 0);
        enable = 1'b1; trig_mode = 1'b1;
        ndrdy1 = 1'b0; ndrdy4 = 1'b0; ndrdy2 = 1'b0; tick(6);
        ndrdy1 = 1'b1; ndrdy4 = 1'b1; ndrdy2 = 1'b1; tick(6);
        chk("t6_mode1_ignores_drdy", nfall[0] + nfall[1] + nfall[2], 0);
        trig_mode = 1'b0;
        start1 = 1'b1; start4 = 1'b1; start2 = 1'b1; tick(1);
        start1 = 1'b0; start4 = 1'b0; start2 = 1'b0; tick(6);
        chk("t6_mode0_ignores_start", nfall[0] + nfall[1] + nfall[2], 0);
        chk("t6_busy", 32'(busy4), 0);

        // Random words and trigger source on the four-channel reader.
        for (int k = 0; k < 4; k++) begin
            clr();
            for (int i = 0; i < 4; i++) word4[i] = 16'($urandom);
            trig_mode = 1'($urandom_range(1, 0));
            if (trig_mode) pulse(1);
            else ndrdy4 = 1'b0;
            wait_busy(1, 1'b1, 10, "t7_busy_rise");
            ndrdy4 = 1'b1;
            wait_busy(1, 1'b0, 1000, "t7_busy_fall");
            check_scan4("t7");
            chk("t7_overrun", 32'(ovr4), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
